pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM, redirect flush, load-use stall.
// Optional perf counters are built only when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_read,
  input  logic        ex_reg_wen,
  input  logic [4:0]  ex_reg_waddr,
  input  logic        ex_redirect,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic        mem_busy,
  output logic        dmem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {IDLE, MEM_WAIT} state_e;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic            freeze, redirect, load_use, lu_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    freeze     = 1'b0;
    dmem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_access) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            state_d = MEM_WAIT;
            freeze  = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          // Saturate so the sticky flag cannot be missed on wrap.
          if (wait_cnt_q != TMO) wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == TMO) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any outstanding request immediately.
    if (rst) begin
      dmem_req = 1'b0;
      freeze   = 1'b0;
    end
  end

  assign lu_hit = ex_mem_read && ex_reg_wen && (ex_reg_waddr != 5'd0) &&
                  ((id_rs1_used && (id_rs1 == ex_reg_waddr)) ||
                   (id_rs2_used && (id_rs2 == ex_reg_waddr)));

  // EX is held while frozen, so a redirect there is acted on at release.
  assign redirect = !rst && !freeze && ex_redirect;
  assign load_use = !rst && !freeze && !ex_redirect && lu_hit;

  assign pc_stall      = freeze || load_use;
  assign if_id_stall   = freeze || load_use;
  assign id_ex_stall   = freeze;
  assign ex_mem_stall  = freeze;
  assign mem_wb_bubble = freeze;
  assign if_id_flush   = redirect;
  assign id_ex_flush   = redirect || load_use;
  assign mem_busy      = (state_q == MEM_WAIT);
  assign dmem_timeout  = timeout_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_id_flush || id_ex_flush) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_reg_waddr;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_reg_wen, ex_redirect;
  logic mem_access, dmem_ready;
  logic dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_busy, dmem_timeout;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_read(ex_mem_read), .ex_reg_wen(ex_reg_wen), .ex_reg_waddr(ex_reg_waddr),
    .ex_redirect(ex_redirect), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble), .mem_busy(mem_busy),
    .dmem_timeout(dmem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int n_vec = 0, n_err = 0;

  // Reference model state: is a memory request outstanding, how long, error seen.
  bit          m_wait, m_to;
  int          m_cnt;
  logic [31:0] m_stall, m_flush;
  bit          e_frz, e_redir, e_lu;
  int          a_req, a_frz, a_busy, a_fl, a_lu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [9:0] obs, exp;
    bit hz;
    @(negedge clk);
    hz = ex_mem_read && ex_reg_wen && ex_reg_waddr != 0 &&
         ((id_rs1_used && id_rs1 == ex_reg_waddr) || (id_rs2_used && id_rs2 == ex_reg_waddr));
    e_frz   = !rst && !dmem_ready && (m_wait || mem_access);
    e_redir = !rst && !e_frz && ex_redirect;
    e_lu    = !rst && !e_frz && !ex_redirect && hz;
    exp = {!rst && (m_wait || mem_access), e_frz || e_lu, e_frz || e_lu, e_frz, e_frz,
           e_redir, e_redir || e_lu, e_frz, m_wait, m_to};
    obs = {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_busy, dmem_timeout};
    chk("flags", {22'd0, obs}, {22'd0, exp});
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
    a_req  += int'(dmem_req);
    a_frz  += int'(id_ex_stall);
    a_busy += int'(mem_busy);
    a_fl   += int'(if_id_flush);
    a_lu   += int'(pc_stall && !id_ex_stall);
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
`ifdef PIPE_HAZARD_PERF_CNT_EN
      if (e_frz || e_lu) m_stall = m_stall + 32'd1;
      if (e_redir || e_lu) m_flush = m_flush + 32'd1;
`endif
      if (m_wait) begin
        if (dmem_ready) begin m_wait = 0; m_cnt = 0; end
        else begin
          if (m_cnt < T) m_cnt++;
          if (m_cnt == T) m_to = 1;
        end
      end else if (mem_access && !dmem_ready) m_wait = 1;
    end
    #1;
  endtask

  task automatic idle_in();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_read = 0; ex_reg_wen = 0; ex_reg_waddr = 0; ex_redirect = 0;
    mem_access = 0; dmem_ready = 0;
  endtask

  task automatic clr_acc();
    a_req = 0; a_frz = 0; a_busy = 0; a_fl = 0; a_lu = 0;
  endtask

  task automatic set_lu(input logic [4:0] waddr);
    ex_mem_read = 1; ex_reg_wen = 1; ex_reg_waddr = waddr; id_rs1 = 5; id_rs1_used = 1;
  endtask

  initial begin
    m_wait = 0; m_to = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    idle_in();
    rst = 1;
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    tick(); tick();
    rst = 0;
    chk("rst_busy", {31'd0, mem_busy}, 32'd0);
    chk("rst_timeout", {31'd0, dmem_timeout}, 32'd0);

    // Load-use, one cycle, then the load moves on (EX gets a bubble)
    clr_acc(); set_lu(5); tick(); idle_in(); tick();
    chk("lu_one_cycle", a_lu, 1);
    clr_acc(); set_lu(0); tick(); idle_in();
    chk("lu_x0_none", a_lu, 0);

    // Redirect overrides load-use
    set_lu(5); ex_redirect = 1; #1;
    chk("redir_lu_pc", {31'd0, pc_stall}, 32'd0);
    chk("redir_lu_fl", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    tick(); idle_in();

    // Three wait cycles then ready
    clr_acc(); mem_access = 1;
    tick(); tick(); tick();
    dmem_ready = 1; tick();
    chk("wait3_req", a_req, 4);
    chk("wait3_frz", a_frz, 3);
    chk("wait3_busy", a_busy, 3);
    idle_in(); tick();
    chk("wait3_idle", {31'd0, mem_busy}, 32'd0);

    // Redirect held across a 2-cycle wait
    clr_acc(); mem_access = 1; ex_redirect = 1;
    tick(); tick();
    chk("redir_frz_nofl", a_fl, 0);
    dmem_ready = 1; tick();
    chk("redir_release_fl", a_fl, 1);
    idle_in(); tick();

    // Timeout: sticky after T wait cycles
    mem_access = 1;
    for (int i = 0; i < T; i++) tick();
    chk("tmo_before", {31'd0, dmem_timeout}, 32'd0);
    tick();
    chk("tmo_set", {31'd0, dmem_timeout}, 32'd1);
    tick(); tick(); dmem_ready = 1; tick(); idle_in(); tick();
    chk("tmo_sticky", {31'd0, dmem_timeout}, 32'd1);
    rst = 1; tick(); rst = 0;
    chk("tmo_clr", {31'd0, dmem_timeout}, 32'd0);

    // Reset in the middle of a wait abandons the request
    mem_access = 1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1; #1;
    chk("rst_wait_req", {31'd0, dmem_req}, 32'd0);
    tick(); idle_in(); rst = 0; #1;
    chk("rst_wait_idle", {31'd0, mem_busy}, 32'd0);
    chk("rst_wait_req2", {31'd0, dmem_req}, 32'd0);
    tick();

`ifdef PIPE_HAZARD_PERF_CNT_EN
    force dut.stall_cycles_q = 32'hFFFFFFFF;
    #1 release dut.stall_cycles_q;
    m_stall = 32'hFFFFFFFF;
    set_lu(5); tick(); idle_in();
    chk("stall_wrap", stall_cycles, 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rs1_used  = 1'($urandom);
      id_rs2_used  = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      ex_reg_wen   = 1'($urandom);
      ex_reg_waddr = 5'($urandom_range(0, 3));
      ex_redirect  = ($urandom_range(0, 3) == 0);
      mem_access   = 1'($urandom);
      dmem_ready   = (i % 100 < 80) ? 1'($urandom) : 1'b0;
      tick();
    end

`ifndef PIPE_HAZARD_PERF_CNT_EN
    chk("cnt_off_stall", stall_cycles, 32'd0);
    chk("cnt_off_flush", flush_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
